// File: rtl/msk_kat_checker.sv
// Known-answer checker for masked cores. It recombines the shared output bus
// and compares each result with a FIFO of expected words, keeping pass/fail statistics.
module msk_kat_checker #(
  parameter int unsigned d         = 2,
  parameter int unsigned W         = 128,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      exp_valid,
  output logic                      exp_ready,
  input  logic [W-1:0]              exp_data,
  input  logic [d*W-1:0]            sh_data_out,
  input  logic                      out_valid,
  output logic                      out_ready,
  input  logic                      bp_en,
  input  logic                      clear,
  output logic [CNT_W-1:0]          pass_cnt,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic                      fail,
  output logic [CNT_W-1:0]          first_fail_idx,
  output logic [W-1:0]              first_fail_data,
  output logic [$clog2(DEPTH):0]    pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [W-1:0]     ffd_q, ffd_d;

  logic             push, pop;
  logic [W-1:0]     rec;
  logic [W-1:0]     head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign exp_ready = (cnt_q != PW'(DEPTH));
  assign out_ready = (cnt_q != '0) & (bp_en ? lfsr_q[0] : 1'b1);
  assign push      = exp_valid & exp_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rptr_q];

  // Recombine shares: bit i is the XOR of its d adjacent shares.
  always_comb begin
    rec = '0;
    for (int i = 0; i < int'(W); i++) begin
      rec[i] = ^sh_data_out[d*i +: d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= exp_data;
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  end

  // Statistics; clear wins over a same-cycle transfer.
  always_comb begin
    pass_d = pass_q;
    fcnt_d = fcnt_q;
    idx_d  = idx_q;
    fail_d = fail_q;
    ffi_d  = ffi_q;
    ffd_d  = ffd_q;
    if (clear) begin
      pass_d = '0;
      fcnt_d = '0;
      idx_d  = '0;
      fail_d = 1'b0;
      ffi_d  = '0;
      ffd_d  = '0;
    end else if (pop) begin
      idx_d = sat_inc(idx_q);
      if (rec == head) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fcnt_d = sat_inc(fcnt_q);
        if (!fail_q) begin
          fail_d = 1'b1;
          ffi_d  = idx_q;
          ffd_d  = rec;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
      pass_q <= '0;
      fcnt_q <= '0;
      idx_q  <= '0;
      fail_q <= 1'b0;
      ffi_q  <= '0;
      ffd_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      pass_q <= pass_d;
      fcnt_q <= fcnt_d;
      idx_q  <= idx_d;
      fail_q <= fail_d;
      ffi_q  <= ffi_d;
      ffd_q  <= ffd_d;
    end
  end

  assign pass_cnt        = pass_q;
  assign fail_cnt        = fcnt_q;
  assign fail            = fail_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_data = ffd_q;
  assign pending         = cnt_q;

endmodule

// File: tb/tb_msk_kat_checker.sv
// Randomized bench for msk_kat_checker against a queue-based reference model.
module tb_msk_kat_checker;

  localparam int unsigned D     = 3;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] SEED  = 32'hACE1_1234;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             exp_valid;
  logic             exp_ready;
  logic [W-1:0]     exp_data;
  logic [D*W-1:0]   sh_data_out;
  logic             out_valid;
  logic             out_ready;
  logic             bp_en;
  logic             clear;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             fail;
  logic [CNT_W-1:0] first_fail_idx;
  logic [W-1:0]     first_fail_data;
  logic [PW-1:0]    pending;

  msk_kat_checker #(
    .d(D), .W(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .sh_data_out(sh_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .bp_en(bp_en), .clear(clear),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail(fail),
    .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] q[$];
  int           m_pass, m_fcnt, m_idx, m_ffi;
  bit           m_fail;
  logic [W-1:0] m_ffd;
  logic [31:0]  m_lfsr;
  int           n_push;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Polynomial x^32+x^22+x^2+x+1, right-shifting Galois form.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = n[31] ^ 1'b1;
      n[21] = n[21] ^ 1'b1;
      n[1]  = n[1]  ^ 1'b1;
      n[0]  = n[0]  ^ 1'b1;
    end
    return n;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pass = 0; m_fcnt = 0; m_idx = 0; m_ffi = 0;
    m_fail = 1'b0; m_ffd = '0;
    m_lfsr = SEED;
  endfunction

  function automatic logic [D*W-1:0] encode(input logic [W-1:0] v);
    logic [D*W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(W); i++) begin
      bit x;
      x = 1'b0;
      for (int j = 0; j < int'(D) - 1; j++) begin
        s[D*i+j] = 1'($urandom);
        x ^= s[D*i+j];
      end
      s[D*i+D-1] = v[i] ^ x;
    end
    return s;
  endfunction

  // One clock cycle: drive at negedge, check handshake, update model, check stats.
  task automatic cycle(input bit ev, input logic [W-1:0] ed, input bit ov,
                       input logic [W-1:0] rv, input bit clr);
    bit           m_rdy, m_push, m_pop;
    logic [W-1:0] head;
    exp_valid   = ev;
    exp_data    = ed;
    out_valid   = ov;
    clear       = clr;
    sh_data_out = encode(rv);
    #1;
    m_rdy  = (q.size() != 0) && (bp_en ? m_lfsr[0] : 1'b1);
    m_push = ev && (q.size() != DEPTH);
    m_pop  = ov && m_rdy;
    chk("out_ready", 64'(out_ready), 64'(m_rdy));
    chk("exp_ready", 64'(exp_ready), 64'(q.size() != DEPTH));
    @(posedge clk);
    if (m_pop) begin
      head = q.pop_front();
      if (!clr) begin
        if (head == rv) m_pass = sat(m_pass);
        else begin
          m_fcnt = sat(m_fcnt);
          if (!m_fail) begin
            m_fail = 1'b1;
            m_ffi  = m_idx;
            m_ffd  = rv;
          end
        end
        m_idx = sat(m_idx);
      end
    end
    if (clr) begin
      m_pass = 0; m_fcnt = 0; m_idx = 0; m_ffi = 0; m_fail = 1'b0; m_ffd = '0;
    end
    if (m_push) begin
      q.push_back(ed);
      n_push++;
    end
    m_lfsr = lfsr_next(m_lfsr);
    @(negedge clk);
    chk("pending", 64'(pending), 64'(q.size()));
    chk("pass_cnt", 64'(pass_cnt), 64'(m_pass));
    chk("fail_cnt", 64'(fail_cnt), 64'(m_fcnt));
    chk("fail", 64'(fail), 64'(m_fail));
    chk("first_fail_idx", 64'(first_fail_idx), 64'(m_ffi));
    chk("first_fail_data", 64'(first_fail_data), 64'(m_ffd));
  endtask

  function automatic logic [W-1:0] head_or_rand();
    return (q.size() != 0) ? q[0] : W'($urandom);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_exp_ready", 64'(exp_ready), 64'd1);
    chk("rst_out_ready", 64'(out_ready), 64'd0);
    chk("rst_pass", 64'(pass_cnt), 64'd0);
    chk("rst_fail_cnt", 64'(fail_cnt), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_ffi", 64'(first_fail_idx), 64'd0);
    chk("rst_ffd", 64'(first_fail_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    exp_valid = 1'b0; exp_data = '0; out_valid = 1'b0; sh_data_out = '0;
    bp_en = 1'b0; clear = 1'b0; n_push = 0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Matching stream
    for (int k = 0; k < 4; k++) cycle(1'b1, W'(32'hA5A5_A500 + k), 1'b0, '0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, W'(32'hA5A5_A500 + k), 1'b0);
    chk("stream_pass", 64'(pass_cnt), 64'd4);
    chk("stream_fail_cnt", 64'(fail_cnt), 64'd0);
    chk("stream_pending", 64'(pending), 64'd0);

    // Mismatch capture: 3rd and 5th transfers mismatch
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, W'(32'h1000 + k), 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      w = W'(32'h1000 + k);
      if (k == 2) w = 32'hDEAD_BEEF;
      if (k == 4) w = w ^ 32'h1;
      cycle(1'b0, '0, 1'b1, w, 1'b0);
    end
    chk("mm_fail", 64'(fail), 64'd1);
    chk("mm_fail_cnt", 64'(fail_cnt), 64'd2);
    chk("mm_ffi", 64'(first_fail_idx), 64'd2);
    chk("mm_ffd", 64'(first_fail_data), 64'hDEAD_BEEF);

    // FIFO full / empty
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < int'(DEPTH) + 2; k++) cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    chk("full_pending", 64'(pending), 64'(DEPTH));
    chk("full_exp_ready", 64'(exp_ready), 64'd0);
    for (int k = 0; k < 4; k++) cycle(1'b1, W'($urandom), 1'b1, head_or_rand(), 1'b0);
    for (int k = 0; k < int'(DEPTH) + 2 && q.size() != 0; k++)
      cycle(1'b0, '0, 1'b1, head_or_rand(), 1'b0);
    chk("empty_out_ready", 64'(out_ready), 64'd0);
    chk("empty_pending", 64'(pending), 64'd0);

    // Clear during a transfer: pop happens, stats and idx end at 0
    cycle(1'b1, 32'h55, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h66, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'h55, 1'b1);
    chk("clr_pending", 64'(pending), 64'd1);
    chk("clr_pass", 64'(pass_cnt), 64'd0);
    cycle(1'b0, '0, 1'b1, 32'h67, 1'b0);
    chk("clr_ffi", 64'(first_fail_idx), 64'd0);
    chk("clr_ffd", 64'(first_fail_data), 64'h67);

    // Back-pressure reproducible from seed after two resets
    bp_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int k = 0; k < int'(DEPTH); k++) cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
      for (int k = 0; k < 64; k++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    end
    for (int k = 0; k < 4 * int'(DEPTH) && q.size() != 0; k++)
      cycle(1'b0, '0, 1'b1, head_or_rand(), 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    n_push = 0;
    for (int k = 0; k < 1000; k++)
      cycle(($urandom % 5) == 0, W'($urandom), ($urandom % 4) != 0, head_or_rand(), 1'b0);
    for (int k = 0; k < 2000 && q.size() != 0; k++)
      cycle(1'b0, '0, 1'b1, head_or_rand(), 1'b0);
    chk("bp_pass_eq_push", 64'(pass_cnt), 64'((n_push > CMAX) ? CMAX : n_push));
    chk("bp_fail_cnt", 64'(fail_cnt), 64'd0);
    chk("bp_pending", 64'(pending), 64'd0);

    // Random mix with mismatches, clears and toggling back-pressure
    for (int k = 0; k < 600; k++) begin
      bp_en = (($urandom % 8) == 0) ? ~bp_en : bp_en;
      w = head_or_rand();
      if (($urandom % 8) == 0) w = w ^ W'($urandom | 1);
      cycle(($urandom % 3) != 0, W'($urandom), ($urandom % 3) != 0, w, ($urandom % 60) == 0);
    end

    // Saturation at all-ones
    bp_en = 1'b0;
    for (int k = 0; k < 2 * int'(DEPTH) && q.size() != 0; k++)
      cycle(1'b0, '0, 1'b1, head_or_rand(), 1'b0);
    cycle(1'b1, W'($urandom), 1'b0, '0, 1'b1);
    for (int k = 0; k < CMAX + 5; k++) cycle(1'b1, W'($urandom), 1'b1, head_or_rand(), 1'b0);
    chk("sat_pass", 64'(pass_cnt), 64'(CMAX));
    cycle(1'b0, '0, 1'b1, head_or_rand() ^ 32'h1, 1'b0);
    chk("sat_ffi", 64'(first_fail_idx), 64'(CMAX));
    chk("sat_fail_cnt", 64'(fail_cnt), 64'd1);

    // Reset asserted mid-cycle flushes everything
    for (int k = 0; k < 3; k++) cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    #2;
    do_reset();
    cycle(1'b1, 32'h77, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'h77, 1'b0);
    chk("post_rst_pass", 64'(pass_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
